spmv_y_packer: RTL and testbench

SPMV_Y_PACKER -- requirements
Module: spmv_y_packer

---
 rtl/spmv_y_packer_if.sv | 34 +++
 rtl/spmv_y_packer.sv | 126 ++++++++++++
 tb/tb_spmv_y_packer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_y_packer_if.sv
// Bus bundle for spmv_y_packer: job config, fp64 dot-result input stream, packed y output stream.
// The slave modport is the packer's view; the master modport is the job/stream driver's view.
interface spmv_y_packer_if #(
  parameter int unsigned LANES = 8
);
  logic [31:0]         cfg_rows;
  logic                cfg_valid;
  logic                cfg_ready;

  logic [63:0]         S_AXIS_DOT_tdata;
  logic                S_AXIS_DOT_tvalid;
  logic                S_AXIS_DOT_tready;

  logic [64*LANES-1:0] M_AXIS_Y_tdata;
  logic [8*LANES-1:0]  M_AXIS_Y_tkeep;
  logic                M_AXIS_Y_tlast;
  logic                M_AXIS_Y_tvalid;
  logic                M_AXIS_Y_tready;

  logic                busy;
  logic                done;

  modport slave (
    input  cfg_rows, cfg_valid, S_AXIS_DOT_tdata, S_AXIS_DOT_tvalid, M_AXIS_Y_tready,
    output cfg_ready, S_AXIS_DOT_tready, M_AXIS_Y_tdata, M_AXIS_Y_tkeep, M_AXIS_Y_tlast,
           M_AXIS_Y_tvalid, busy, done
  );

  modport master (
    output cfg_rows, cfg_valid, S_AXIS_DOT_tdata, S_AXIS_DOT_tvalid, M_AXIS_Y_tready,
    input  cfg_ready, S_AXIS_DOT_tready, M_AXIS_Y_tdata, M_AXIS_Y_tkeep, M_AXIS_Y_tlast,
           M_AXIS_Y_tvalid, busy, done
  );
endinterface

// File: rtl/spmv_y_packer.sv
// Packs a job's stream of fp64 dot results into LANES-wide y-vector beats, tagging the
// final (possibly partial, zero-padded) beat with tlast and pulsing done when it is accepted.
module spmv_y_packer #(
  parameter int unsigned LANES = 8
) (
  input logic              clk,
  input logic              rstn,
  spmv_y_packer_if.slave   bus
);

  localparam int unsigned DataW = 64 * LANES;
  localparam int unsigned KeepW = 8 * LANES;
  localparam int unsigned LaneW = $clog2(LANES);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e             state_q, state_d;
  logic               init_q;
  logic [31:0]        rem_q, rem_d;
  logic [LaneW-1:0]   lane_q, lane_d;
  logic [DataW-1:0]   buf_q, buf_d, odata_q, odata_d;
  logic [KeepW-1:0]   keep_q, keep_d, okeep_q, okeep_d;
  logic               olast_q, olast_d;
  logic               ovalid_q, ovalid_d;
  logic               done_q, done_d;
  logic               cfg_fire, in_fire, out_fire;

  // cfg_ready stays low until the first clock after reset release.
  assign bus.cfg_ready         = init_q && (state_q == StIdle);
  assign bus.S_AXIS_DOT_tready = (state_q == StCollect) && (!ovalid_q || bus.M_AXIS_Y_tready);

  assign cfg_fire = bus.cfg_valid && bus.cfg_ready;
  assign in_fire  = bus.S_AXIS_DOT_tvalid && bus.S_AXIS_DOT_tready;
  assign out_fire = ovalid_q && bus.M_AXIS_Y_tready;

  assign bus.M_AXIS_Y_tdata  = odata_q;
  assign bus.M_AXIS_Y_tkeep  = okeep_q;
  assign bus.M_AXIS_Y_tlast  = olast_q;
  assign bus.M_AXIS_Y_tvalid = ovalid_q;
  assign bus.busy            = (state_q != StIdle);
  // Zero-row jobs pulse via done_q; normal jobs pulse in the cycle the tlast beat is taken.
  assign bus.done            = done_q || (state_q == StDrain && out_fire && olast_q);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    lane_d   = lane_q;
    buf_d    = buf_q;
    keep_d   = keep_q;
    odata_d  = odata_q;
    okeep_d  = okeep_q;
    olast_d  = olast_q;
    ovalid_d = ovalid_q && !out_fire;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_fire) begin
          rem_d  = bus.cfg_rows;
          lane_d = '0;
          buf_d  = '0;
          keep_d = '0;
          if (bus.cfg_rows == 32'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (in_fire) begin
          buf_d[64*lane_q +: 64] = bus.S_AXIS_DOT_tdata;
          keep_d[8*lane_q +: 8]  = 8'hFF;
          lane_d = lane_q + 1'b1;
          rem_d  = rem_q - 32'd1;
          if (lane_q == LaneW'(LANES - 1) || rem_q == 32'd1) begin
            odata_d  = buf_d;
            okeep_d  = keep_d;
            olast_d  = (rem_q == 32'd1);
            ovalid_d = 1'b1;
            buf_d    = '0;
            keep_d   = '0;
            if (rem_q == 32'd1) begin
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        if (out_fire && olast_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      init_q   <= 1'b0;
      rem_q    <= '0;
      lane_q   <= '0;
      buf_q    <= '0;
      keep_q   <= '0;
      odata_q  <= '0;
      okeep_q  <= '0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= 1'b1;
      rem_q    <= rem_d;
      lane_q   <= lane_d;
      buf_q    <= buf_d;
      keep_q   <= keep_d;
      odata_q  <= odata_d;
      okeep_q  <= okeep_d;
      olast_q  <= olast_d;
      ovalid_q <= ovalid_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_spmv_y_packer.sv
// Scoreboard bench for spmv_y_packer: expected beats are built as rows are driven and
// compared as the packer emits them; also checks reset values, stalls and done/tlast counts.
module tb_spmv_y_packer;

  localparam int unsigned LANES = 8;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spmv_y_packer_if #(.LANES(LANES)) bus ();

  spmv_y_packer #(.LANES(LANES)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int fails  = 0;
  beat_t exp_q[$];

  int beats_seen = 0;
  int done_cnt   = 0;
  int last_cnt   = 0;
  logic [511:0] last_data;
  logic [63:0]  last_keep;
  bit stop_rand;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard pop/compare, hold-stability, done and tlast counting.
  logic         hold_v = 1'b0;
  logic [511:0] hold_d;
  logic [63:0]  hold_k;
  logic         hold_l;
  always @(negedge clk) begin
    if (!rstn) begin
      hold_v = 1'b0;
      exp_q.delete();
    end else begin
      if (bus.done) done_cnt++;
      if (hold_v) begin
        check("hold_data", bus.M_AXIS_Y_tdata, hold_d);
        check("hold_keep", bus.M_AXIS_Y_tkeep, hold_k);
        check("hold_last", bus.M_AXIS_Y_tlast, hold_l);
        check("hold_valid", bus.M_AXIS_Y_tvalid, 1);
      end
      if (bus.M_AXIS_Y_tvalid && bus.M_AXIS_Y_tready) begin
        beats_seen++;
        if (bus.M_AXIS_Y_tlast) last_cnt++;
        last_data = bus.M_AXIS_Y_tdata;
        last_keep = bus.M_AXIS_Y_tkeep;
        if (exp_q.size() == 0) begin
          check("beat_unexpected", bus.M_AXIS_Y_tvalid, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", bus.M_AXIS_Y_tdata, e.d);
          check("beat_keep", bus.M_AXIS_Y_tkeep, e.k);
          check("beat_last", bus.M_AXIS_Y_tlast, e.l);
        end
      end
      hold_v = bus.M_AXIS_Y_tvalid && !bus.M_AXIS_Y_tready;
      hold_d = bus.M_AXIS_Y_tdata;
      hold_k = bus.M_AXIS_Y_tkeep;
      hold_l = bus.M_AXIS_Y_tlast;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_m_tvalid"}, bus.M_AXIS_Y_tvalid, 0);
    check({tag, "_m_tdata"}, bus.M_AXIS_Y_tdata, 0);
    check({tag, "_m_tkeep"}, bus.M_AXIS_Y_tkeep, 0);
    check({tag, "_m_tlast"}, bus.M_AXIS_Y_tlast, 0);
    check({tag, "_s_tready"}, bus.S_AXIS_DOT_tready, 0);
    check({tag, "_cfg_ready"}, bus.cfg_ready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic start_job(input int rows);
    int n = 0;
    bus.cfg_rows  = 32'(rows);
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    while (!bus.cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cfg_handshake_in_time", n < 100, 1);
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input bit rnd);
    int n = 0;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.S_AXIS_DOT_tdata  = d;
    bus.S_AXIS_DOT_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.S_AXIS_DOT_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("s_handshake_in_time", n < 1000, 1);
    @(posedge clk);
    #1;
    bus.S_AXIS_DOT_tvalid = 1'b0;
  endtask

  task automatic run_job(input string name, input int rows, input bit use_real, input bit rnd);
    int b0 = beats_seen;
    int d0 = done_cnt;
    int l0 = last_cnt;
    int n  = 0;
    logic [511:0] bd = '0;
    logic [63:0]  bk = '0;
    logic [63:0]  d;
    beat_t e;
    start_job(rows);
    if (rows == 0) begin
      @(negedge clk);
      check({name, "_zero_done_pulse"}, bus.done, 1);
    end
    for (int k = 0; k < rows; k++) begin
      int lane;
      lane = k % 8;
      d = use_real ? $realtobits(real'(k + 1)) : {$urandom(), $urandom()};
      bd[64*lane +: 64] = d;
      bk[8*lane +: 8]   = 8'hFF;
      if (lane == 7 || k == rows - 1) begin
        e.d = bd;
        e.k = bk;
        e.l = (k == rows - 1);
        exp_q.push_back(e);
        bd = '0;
        bk = '0;
      end
      send(d, rnd);
    end
    while (done_cnt == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({name, "_done_count"}, done_cnt - d0, 1);
    check({name, "_beats"}, beats_seen - b0, (rows + 7) / 8);
    check({name, "_tlast_count"}, last_cnt - l0, (rows == 0) ? 0 : 1);
    check({name, "_sb_empty"}, exp_q.size(), 0);
    check({name, "_cfg_ready_back"}, bus.cfg_ready, 1);
    check({name, "_busy_low"}, bus.busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0;
    int n;
    bus.cfg_rows          = '0;
    bus.cfg_valid         = 1'b0;
    bus.S_AXIS_DOT_tdata  = '0;
    bus.S_AXIS_DOT_tvalid = 1'b0;
    bus.M_AXIS_Y_tready   = 1'b1;

    #1;
    check_reset_values("por");
    #11;
    rstn = 1'b1;
    #1;
    check("cfg_ready_before_first_clk", bus.cfg_ready, 0);
    @(posedge clk);
    #1;
    check("cfg_ready_after_first_clk", bus.cfg_ready, 1);

    // One full beat of 1.0..8.0.
    run_job("full8", 8, 1'b1, 1'b0);
    check("full8_lane0", last_data[63:0], 64'h3FF0000000000000);
    check("full8_keep", last_keep, 64'hFFFF_FFFF_FFFF_FFFF);

    // Partial second beat.
    run_job("part11", 11, 1'b1, 1'b0);
    check("part11_keep", last_keep, 64'h0000_0000_00FF_FFFF);
    check("part11_upper_zero", last_data[511:192], 0);

    // Downstream stall for 10 cycles once the first beat is up.
    bus.M_AXIS_Y_tready = 1'b0;
    fork
      run_job("stall16", 16, 1'b0, 1'b0);
      begin
        n = 0;
        while (!bus.M_AXIS_Y_tvalid && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("stall_first_beat_seen", n < 200, 1);
        repeat (10) begin
          @(negedge clk);
          check("stall_s_tready_low", bus.S_AXIS_DOT_tready, 0);
        end
        @(posedge clk);
        #1;
        bus.M_AXIS_Y_tready = 1'b1;
      end
    join

    // Zero-row job: done only, no beat.
    run_job("zero", 0, 1'b0, 1'b0);

    // Reset in the middle of a 20-row job.
    start_job(20);
    for (int k = 0; k < 5; k++) send({32'hDEAD_0000, 32'(k)}, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_reset_values("midjob_rst");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    b0 = beats_seen;
    repeat (10) @(negedge clk);
    check("post_rst_no_beat", beats_seen - b0, 0);
    check("post_rst_no_tvalid", bus.M_AXIS_Y_tvalid, 0);
    @(posedge clk);
    #1;
    run_job("post_rst1", 1, 1'b0, 1'b0);
    check("post_rst1_keep", last_keep, 64'h0000_0000_0000_00FF);

    // Random source gaps and random downstream backpressure.
    stop_rand = 1'b0;
    fork
      begin
        run_job("rand1000", 1000, 1'b0, 1'b1);
        stop_rand = 1'b1;
      end
      while (!stop_rand) begin
        @(posedge clk);
        #1;
        if (!stop_rand) bus.M_AXIS_Y_tready = ($urandom_range(0, 3) != 0);
      end
    join
    bus.M_AXIS_Y_tready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
